div_ratio_meter: RTL and testbench

//  Receive-side checker for the clock divider outputs (f2, f4, or any divided clock).

---
 rtl/div_ratio_meter.sv | 177 +++++++++++++++++
 tb/tb_div_ratio_meter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ratio_meter.sv
// div_ratio_meter
//   Receive-side checker for divided clocks. Samples a slow periodic signal
//   in the clk domain and measures its period (rising edge to rising edge)
//   and its high time, both in clk cycles. Each measurement is published with
//   a one-cycle valid. Lock is flagged after LOCK_COUNT consecutive equal
//   periods. A one-cycle timeout pulse is raised when no rising edge arrives
//   within TIMEOUT cycles.
//
// Parameters
//   CNT_W        width of the period/high counters and outputs
//   SYNC_STAGES  sig_in synchronizer depth, 0..3 (0 = already clk-synchronous)
//   LOCK_COUNT   consecutive equal periods needed for locked (>= 2)
//   TIMEOUT      longest legal period in clk cycles (< 2**CNT_W)
//
// Ports
//   clk          system clock, everything on the rising edge
//   reset        asynchronous, active-low reset
//   en           measurement enable; low forces the idle state
//   sig_in       divided signal under test
//   period       last measured period, clk cycles
//   high_time    cycles the synchronized signal was high within that period
//   meas_valid   one-cycle pulse: period/high_time just updated
//   locked       LOCK_COUNT consecutive identical periods seen
//   timeout      one-cycle pulse: no rising edge within TIMEOUT cycles

module div_ratio_meter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_COUNT  = 4,
   parameter int TIMEOUT     = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);

   // The streak saturates at LOCK_COUNT, so it only needs to hold that value.
   localparam int STRK_W = $clog2(LOCK_COUNT + 1);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE
   } state_t;

   state_t              state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [CNT_W-1:0]    hcnt_reg;
   logic [STRK_W-1:0]   streak_reg;
   logic [STRK_W-1:0]   streak_next;
   logic                s;
   logic                s_d_reg;
   logic                rise;

   // ------------------------------------------------------------------
   // Input synchronizer
   // ------------------------------------------------------------------
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = sig_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               sync_reg <= '0;
            end else begin
               sync_reg[0] <= sig_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_reg[i] <= sync_reg[i-1];
               end
            end
         end

         assign s = sync_reg[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_d_reg <= 1'b0;
      end else begin
         s_d_reg <= s;
      end
   end

   assign rise = s & ~s_d_reg;

   // ------------------------------------------------------------------
   // Streak update for a publish happening this cycle. A zero streak means
   // this is the first publish since arming, which always starts a new run.
   // ------------------------------------------------------------------
   always_comb begin
      streak_next = STRK_W'(1);
      if (streak_reg != '0 && cnt_reg == period) begin
         if (streak_reg == STRK_W'(LOCK_COUNT)) begin
            streak_next = streak_reg;
         end else begin
            streak_next = streak_reg + STRK_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Measurement FSM with registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         hcnt_reg   <= '0;
         streak_reg <= '0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
         if (!en) begin
            // Disable wins over anything else this cycle, including a rise.
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            hcnt_reg   <= '0;
            streak_reg <= '0;
            locked     <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  state_reg <= ARM;
               end
               ARM: begin
                  if (rise) begin
                     cnt_reg   <= CNT_W'(1);
                     hcnt_reg  <= CNT_W'(1);
                     state_reg <= MEASURE;
                  end
               end
               MEASURE: begin
                  if (rise) begin
                     // cnt holds the cycle distance back to the previous rise.
                     period     <= cnt_reg;
                     high_time  <= hcnt_reg;
                     meas_valid <= 1'b1;
                     streak_reg <= streak_next;
                     locked     <= (streak_next >= STRK_W'(LOCK_COUNT));
                     cnt_reg    <= CNT_W'(1);
                     hcnt_reg   <= CNT_W'(1);
                  end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
                     // Edges stopped: re-arm and keep the last measurement.
                     timeout    <= 1'b1;
                     locked     <= 1'b0;
                     streak_reg <= '0;
                     cnt_reg    <= '0;
                     hcnt_reg   <= '0;
                     state_reg  <= ARM;
                  end else begin
                     cnt_reg  <= cnt_reg + CNT_W'(1);
                     hcnt_reg <= hcnt_reg + CNT_W'(s);
                  end
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_div_ratio_meter.sv
// Testbench for div_ratio_meter: table-driven ratio scenarios, hand-written
// control/timeout sequences and randomized stimulus, all checked every cycle
// against a timestamp-based reference model of the measurement rules.

module tb_div_ratio_meter;

   localparam int CNT_W = 16;
   localparam int SYNC  = 2;
   localparam int LOCKN = 4;
   localparam int TO    = 20;

   localparam int M_IDLE = 0;
   localparam int M_ARM  = 1;
   localparam int M_MEAS = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             en = 1'b0;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             locked;
   logic             timeout;

   div_ratio_meter #(
      .CNT_W(CNT_W),
      .SYNC_STAGES(SYNC),
      .LOCK_COUNT(LOCKN),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .sig_in(sig_in),
      .period(period),
      .high_time(high_time),
      .meas_valid(meas_valid),
      .locked(locked),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int vcnt    = 0;
   int tcnt    = 0;

   function automatic void check(string name, longint act, longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // ------------------------------------------------------------------
   // Reference model: rise timestamps and per-cycle level history.
   // ------------------------------------------------------------------
   bit xq[$];          // raw sig_in samples since reset (last SYNC+1)
   int hq[$];          // synchronized levels since the last accepted rise
   int pubs[$];        // periods published since arming
   int mode = M_IDLE;
   int edge_n = 0;
   int last_rise = 0;
   bit m_s, m_r, s_prev = 1'b0;
   int exp_period = 0;
   int exp_high = 0;
   bit exp_valid = 1'b0;
   bit exp_to = 1'b0;
   bit exp_locked = 1'b0;

   function automatic bit model_lock();
      if (pubs.size() < LOCKN) return 1'b0;
      for (int i = 1; i < LOCKN; i++) begin
         if (pubs[pubs.size()-1-i] != pubs[pubs.size()-1]) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         xq.delete(); hq.delete(); pubs.delete();
         mode = M_IDLE; edge_n = 0; last_rise = 0; s_prev = 1'b0;
         exp_period = 0; exp_high = 0;
         exp_valid = 1'b0; exp_to = 1'b0; exp_locked = 1'b0;
      end else begin
         edge_n++;
         xq.push_back(sig_in);
         if (xq.size() > SYNC + 1) void'(xq.pop_front());
         m_s = (xq.size() == SYNC + 1) ? xq[0] : 1'b0;
         m_r = m_s & ~s_prev;
         s_prev = m_s;
         exp_valid = 1'b0;
         exp_to = 1'b0;
         if (!en) begin
            mode = M_IDLE;
            pubs.delete();
            exp_locked = 1'b0;
         end else if (mode == M_IDLE) begin
            mode = M_ARM;
         end else if (mode == M_ARM) begin
            if (m_r) begin
               last_rise = edge_n;
               hq.delete(); hq.push_back(1);
               mode = M_MEAS;
            end
         end else begin
            if (m_r) begin
               exp_period = edge_n - last_rise;
               exp_high = hq.sum();
               exp_valid = 1'b1;
               pubs.push_back(exp_period);
               exp_locked = model_lock();
               last_rise = edge_n;
               hq.delete(); hq.push_back(1);
            end else if (edge_n - last_rise == TO) begin
               exp_to = 1'b1;
               exp_locked = 1'b0;
               pubs.delete();
               mode = M_ARM;
            end else begin
               hq.push_back(int'(m_s));
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("period", period, exp_period);
      check("high_time", high_time, exp_high);
      check("meas_valid", meas_valid, exp_valid);
      check("timeout", timeout, exp_to);
      check("locked", locked, exp_locked);
      check("pulse_overlap", meas_valid & timeout, 0);
      if (meas_valid) vcnt++;
      if (timeout) tcnt++;
   end

   // ------------------------------------------------------------------
   // Stimulus helpers: inputs change 2 time units after the rising edge.
   // ------------------------------------------------------------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic drive(input int hi, input int lo, input int n);
      repeat (n) begin
         sig_in = 1'b1; cyc(hi);
         sig_in = 1'b0; cyc(lo);
      end
   endtask

   typedef struct {
      int hi;
      int lo;
      int exp_period;
      int exp_high;
      bit exp_lock;
      bit exp_pub;
      bit exp_to;
   } vec_t;

   vec_t tbl[5];
   int v0, t0;

   initial begin
      tbl[0] = '{1, 1, 2, 1, 1'b1, 1'b1, 1'b0};    // f2
      tbl[1] = '{2, 2, 4, 2, 1'b1, 1'b1, 1'b0};    // f4
      tbl[2] = '{2, 3, 5, 2, 1'b1, 1'b1, 1'b0};    // switch /4 -> /5
      tbl[3] = '{5, 15, 20, 5, 1'b1, 1'b1, 1'b0};  // period exactly TIMEOUT
      tbl[4] = '{5, 16, 20, 5, 1'b0, 1'b0, 1'b1};  // period TIMEOUT+1

      // Reset state
      cyc(3);
      check("rst_period", period, 0);
      check("rst_high", high_time, 0);
      check("rst_valid", meas_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_timeout", timeout, 0);
      reset = 1'b1;
      en = 1'b1;
      cyc(2);

      // Table-driven ratio scenarios
      for (int i = 0; i < 5; i++) begin
         drive(tbl[i].hi, tbl[i].lo, 2);
         v0 = vcnt; t0 = tcnt;
         drive(tbl[i].hi, tbl[i].lo, 8);
         check("vec_period", period, tbl[i].exp_period);
         check("vec_high", high_time, tbl[i].exp_high);
         check("vec_locked", locked, tbl[i].exp_lock);
         check("vec_published", (vcnt - v0) > 0, tbl[i].exp_pub);
         check("vec_timed_out", (tcnt - t0) > 0, tbl[i].exp_to);
         $display("[TB] vec %0d hi=%0d lo=%0d period=%0d high=%0d locked=%0d pubs=%0d tmo=%0d",
                  i, tbl[i].hi, tbl[i].lo, period, high_time, locked, vcnt - v0, tcnt - t0);
      end

      // Stuck high after one rise: single timeout, then two rises publish.
      drive(2, 2, 6);
      en = 1'b0; cyc(2); en = 1'b1;
      sig_in = 1'b0; cyc(4);
      v0 = vcnt; t0 = tcnt;
      sig_in = 1'b1; cyc(40);
      check("stuck_timeouts", tcnt - t0, 1);
      check("stuck_pubs", vcnt - v0, 0);
      check("stuck_locked", locked, 0);
      check("stuck_period_held", period, 4);
      sig_in = 1'b0; cyc(3);
      v0 = vcnt;
      drive(2, 2, 3);
      check("recover_pubs", (vcnt - v0) > 0, 1);
      check("recover_period", period, 4);
      $display("[TB] stuck-high: timeouts=%0d period=%0d locked=%0d", tcnt - t0, period, locked);

      // Reset mid-period: outputs clear at once; publish needs two fresh rises.
      drive(2, 2, 6);
      sig_in = 1'b1; cyc(1);
      reset = 1'b0;
      #1;
      check("mid_rst_period", period, 0);
      check("mid_rst_high", high_time, 0);
      check("mid_rst_locked", locked, 0);
      check("mid_rst_valid", meas_valid, 0);
      check("mid_rst_timeout", timeout, 0);
      sig_in = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(1);
      v0 = vcnt;
      drive(2, 2, 1);
      check("first_rise_no_pub", vcnt - v0, 0);
      drive(2, 2, 1);
      check("second_rise_pub", vcnt - v0, 1);
      $display("[TB] mid-reset: pubs after two rises=%0d", vcnt - v0);

      // en low for 3 cycles while the source keeps toggling.
      drive(2, 2, 6);
      en = 1'b0;
      sig_in = 1'b1;
      @(negedge clk); #1;
      v0 = vcnt; t0 = tcnt;
      cyc(1); sig_in = 1'b0;
      cyc(1); sig_in = 1'b1;
      cyc(1);
      @(negedge clk); #1;
      check("en_off_pubs", vcnt - v0, 0);
      check("en_off_timeouts", tcnt - t0, 0);
      check("en_off_locked", locked, 0);
      check("en_off_period_held", period, 4);
      en = 1'b1;
      cyc(1);
      drive(2, 2, 8);
      check("en_relock", locked, 1);
      $display("[TB] en-drop: period=%0d locked=%0d", period, locked);

      // Randomized stimulus against the model
      for (int it = 0; it < 250; it++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r == 0) begin
            reset = 1'b0; cyc(2); reset = 1'b1;
         end else if (r == 1) begin
            en = 1'b0; cyc($urandom_range(1, 4)); en = 1'b1;
         end else if (r == 2) begin
            repeat (10) begin
               sig_in = 1'($urandom_range(0, 1));
               cyc(1);
            end
         end else begin
            drive($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 4));
         end
      end
      $display("[TB] random: publishes=%0d timeouts=%0d", vcnt, tcnt);

      @(negedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
